// File: rtl/pipe_pkg.sv
// Shared constants, stage-action encoding and a saturating counter helper
// for the pipeline register chain.
package pipe_pkg;

    localparam int DATA_W_DEF = 128;
    localparam int CTRL_W_DEF = 3;

    localparam int CTRL_WREG  = 0;
    localparam int CTRL_M2REG = 1;
    localparam int CTRL_WMEM  = 2;

    localparam int MAX_DEPTH  = 4;
    localparam int STAT_W     = 16;

    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    typedef enum logic [1:0] {
        ACT_KEEP,
        ACT_KILL,
        ACT_LOAD,
        ACT_EMPTY
    } slot_act_e;

    // n is at most MAX_DEPTH, so three bits always suffice.
    function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                  input logic [2:0]        n);
        logic [STAT_W:0] s;
        s = {1'b0, a} + {{(STAT_W-2){1'b0}}, n};
        return s[STAT_W] ? STAT_MAX : s[STAT_W-1:0];
    endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// One pipeline stage: valid/ctrl/data registers with flush > hold > load priority.
// Payload is never cleared on invalid loads, so bubbles do not toggle the data bus.
module pipe_stage_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              src_valid,
    input  logic [CTRL_W-1:0] src_ctrl,
    input  logic [DATA_W-1:0] src_data,
    input  logic              hold,
    input  logic              flush,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic [DATA_W-1:0] data_q,  data_d;
    slot_act_e         act;

    always_comb begin
        if (flush)          act = ACT_KILL;
        else if (hold)      act = ACT_KEEP;
        else if (src_valid) act = ACT_LOAD;
        else                act = ACT_EMPTY;
    end

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        case (act)
            ACT_LOAD: begin
                valid_d = 1'b1;
                ctrl_d  = src_ctrl;
                data_d  = src_data;
            end
            ACT_KILL, ACT_EMPTY: begin
                valid_d = 1'b0;
                ctrl_d  = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

`ifndef SYNTHESIS
    // An empty stage must never present side-effect control bits.
    always_ff @(posedge clock) begin
        if (resetn) assert (valid_q || (ctrl_q == '0));
    end
`endif

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// DEPTH-stage pipeline register chain with hold, entry bubble and per-stage flush.
// Optional bubble/flush statistics counters are built when PIPE_STAT_EN is defined.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DEPTH  = 1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              in_valid,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              hold,
    input  logic              bubble,
    input  logic [DEPTH-1:0]  flush,
    output logic              out_valid,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [DEPTH-1:0]  stage_vld,
    output logic [STAT_W-1:0] bubble_cnt,
    output logic [STAT_W-1:0] flush_cnt
);

    logic [DEPTH-1:0]  vld_s;
    logic [CTRL_W-1:0] ctrl_s [DEPTH];
    logic [DATA_W-1:0] data_s [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic              src_valid;
            logic [CTRL_W-1:0] src_ctrl;
            logic [DATA_W-1:0] src_data;

            if (gi == 0) begin : g_head
                assign src_valid = in_valid & ~bubble;
                assign src_ctrl  = in_ctrl;
                assign src_data  = in_data;
            end else begin : g_body
                assign src_valid = vld_s[gi-1];
                assign src_ctrl  = ctrl_s[gi-1];
                assign src_data  = data_s[gi-1];
            end

            pipe_stage_slot #(
                .DATA_W (DATA_W),
                .CTRL_W (CTRL_W)
            ) u_slot (
                .clock     (clock),
                .resetn    (resetn),
                .src_valid (src_valid),
                .src_ctrl  (src_ctrl),
                .src_data  (src_data),
                .hold      (hold),
                .flush     (flush[gi]),
                .valid_o   (vld_s[gi]),
                .ctrl_o    (ctrl_s[gi]),
                .data_o    (data_s[gi])
            );
        end
    endgenerate

    assign out_valid = vld_s[DEPTH-1];
    assign out_ctrl  = ctrl_s[DEPTH-1];
    assign out_data  = data_s[DEPTH-1];
    assign stage_vld = vld_s;

`ifdef PIPE_STAT_EN
    logic [STAT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [STAT_W-1:0] flush_cnt_q,  flush_cnt_d;
    logic [2:0]        kill_n;

    // Only real instructions count: a bubble with in_valid=0 or a flush of an empty stage is free.
    always_comb begin
        kill_n = '0;
        for (int i = 0; i < DEPTH; i++) begin
            kill_n = kill_n + 3'(flush[i] & vld_s[i]);
        end
        bubble_cnt_d = (!hold && bubble && in_valid) ? sat_add(bubble_cnt_q, 3'd1) : bubble_cnt_q;
        flush_cnt_d  = sat_add(flush_cnt_q, kill_n);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;
`else
    assign bubble_cnt = '0;
    assign flush_cnt  = '0;
`endif

endmodule
